// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between the instruction-side and data-side
// cache controllers. It latches the winner's command, holds the strobes and aborts on timeout.
module mem_port_arbiter #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_req,
   input  logic        i_we,
   input  logic [31:0] i_addr,
   input  logic [31:0] i_wdata,
   input  logic [3:0]  i_be,
   output logic        i_done,
   output logic        i_err,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   input  logic [3:0]  d_be,
   output logic        d_done,
   output logic        d_err,
   output logic [31:0] rdata,
   output logic        mem_ren,
   output logic        mem_wen,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_be,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata,
   output logic        busy,
   output logic        owner
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   // Exit happens on this count, so the 8-bit counter never wraps.
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

   state_t      state_reg, state_next;
   logic        last_reg, owner_reg, err_reg;
   logic        mem_ren_reg, mem_wen_reg;
   logic [7:0]  cnt_reg;
   logic [31:0] rdata_reg, mem_addr_reg, mem_wdata_reg;
   logic [3:0]  mem_be_reg;
   logic        win, sel_we, timeout_hit;

   always_comb begin
      win         = (i_req && d_req) ? ~last_reg : d_req;
      sel_we      = win ? d_we : i_we;
      state_next  = state_reg;
      timeout_hit = 1'b0;
      case (state_reg)
         IDLE: begin
            if (i_req || d_req) state_next = BUSY;
         end
         BUSY: begin
            if (mem_ready) begin
               state_next = DONE;
            end else if (cnt_reg == TO_LAST) begin
               timeout_hit = 1'b1;
               state_next  = DONE;
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg     <= IDLE;
         last_reg      <= 1'b1;
         owner_reg     <= 1'b0;
         err_reg       <= 1'b0;
         mem_ren_reg   <= 1'b0;
         mem_wen_reg   <= 1'b0;
         cnt_reg       <= '0;
         rdata_reg     <= '0;
         mem_addr_reg  <= '0;
         mem_wdata_reg <= '0;
         mem_be_reg    <= '0;
      end else begin
         state_reg <= state_next;
         case (state_reg)
            IDLE: begin
               if (state_next == BUSY) begin
                  owner_reg     <= win;
                  last_reg      <= win;
                  mem_ren_reg   <= ~sel_we;
                  mem_wen_reg   <= sel_we;
                  mem_addr_reg  <= win ? d_addr : i_addr;
                  mem_wdata_reg <= win ? d_wdata : i_wdata;
                  mem_be_reg    <= win ? d_be : i_be;
                  cnt_reg       <= '0;
               end
            end
            BUSY: begin
               if (mem_ready) begin
                  // mem_wen_reg still reflects the latched direction here.
                  if (!mem_wen_reg) rdata_reg <= mem_rdata;
                  err_reg     <= 1'b0;
                  mem_ren_reg <= 1'b0;
                  mem_wen_reg <= 1'b0;
               end else if (timeout_hit) begin
                  err_reg     <= 1'b1;
                  mem_ren_reg <= 1'b0;
                  mem_wen_reg <= 1'b0;
               end else begin
                  cnt_reg <= cnt_reg + 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign i_done    = (state_reg == DONE) && !owner_reg;
   assign d_done    = (state_reg == DONE) && owner_reg;
   assign i_err     = i_done && err_reg;
   assign d_err     = d_done && err_reg;
   assign rdata     = rdata_reg;
   assign mem_ren   = mem_ren_reg;
   assign mem_wen   = mem_wen_reg;
   assign mem_addr  = mem_addr_reg;
   assign mem_wdata = mem_wdata_reg;
   assign mem_be    = mem_be_reg;
   assign busy      = (state_reg != IDLE);
   assign owner     = owner_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: protocol-following requesters, random memory latency,
// and a timestamp-based transaction model predicting every output each cycle.
module tb_mem_port_arbiter;

   localparam int TO   = 4;
   localparam int NCYC = 1500;

   logic        clk = 1'b0;
   logic        reset;
   logic        i_req, i_we, d_req, d_we;
   logic [31:0] i_addr, i_wdata, d_addr, d_wdata;
   logic [3:0]  i_be, d_be;
   logic        i_done, i_err, d_done, d_err;
   logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
   logic        mem_ren, mem_wen, mem_ready, busy, owner;
   logic [3:0]  mem_be;

   int checks = 0;
   int passes = 0;
   int fails  = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset),
      .i_req(i_req), .i_we(i_we), .i_addr(i_addr), .i_wdata(i_wdata), .i_be(i_be),
      .i_done(i_done), .i_err(i_err),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
      .d_done(d_done), .d_err(d_err),
      .rdata(rdata), .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
      .busy(busy), .owner(owner)
   );

   task automatic chk1(input string tag, input int cyc, input logic got, input logic exp);
      checks++;
      assert (got === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s cycle %0d: observed %b expected %b", tag, cyc, got, exp);
      end
   endtask

   task automatic chk32(input string tag, input int cyc, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s cycle %0d: observed %h expected %h", tag, cyc, got, exp);
      end
   endtask

   initial begin
      int          g, done_c, ready_c, next_edge, k, lat, rst_cnt, ntx;
      logic        active, m_last, m_owner, m_we, win, cur_to, force_tie, in_busy, in_done;
      logic [31:0] m_addr, m_wdata, m_rdata, cur_rdata;
      logic [3:0]  m_be;

      reset = 1'b1;
      i_req = 1'b0; i_we = 1'b0; i_addr = '0; i_wdata = '0; i_be = '0;
      d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_be = '0;
      mem_ready = 1'b0; mem_rdata = '0;
      active = 1'b0; m_last = 1'b1; m_owner = 1'b0; m_we = 1'b0; cur_to = 1'b0;
      m_addr = '0; m_wdata = '0; m_be = '0; m_rdata = '0; cur_rdata = '0;
      g = -100; done_c = -100; ready_c = -1; next_edge = 1; rst_cnt = 0; ntx = 0;
      force_tie = 1'b1;

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk1("reset_busy", 0, busy, 1'b0);
      chk1("reset_owner", 0, owner, 1'b0);
      chk1("reset_ren", 0, mem_ren, 1'b0);
      chk1("reset_wen", 0, mem_wen, 1'b0);
      chk1("reset_idone", 0, i_done, 1'b0);
      chk1("reset_ddone", 0, d_done, 1'b0);
      chk32("reset_rdata", 0, rdata, 32'h0);
      chk32("reset_addr", 0, mem_addr, 32'h0);

      for (int c = 1; c <= NCYC; c++) begin
         reset = 1'b0;
         in_busy = active && (c >= g + 1) && (c <= done_c - 1);
         in_done = active && (c == done_c);
         if (in_done && !m_we && !cur_to) m_rdata = cur_rdata;
         if (in_done) begin
            ntx++;
            $display("txn %0d: side=%s we=%0b addr=%h err=%0b rdata=%h", ntx,
                     m_owner ? "D" : "I", m_we, m_addr, cur_to, rdata);
         end

         chk1("busy", c, busy, active && (c >= g + 1) && (c <= done_c));
         chk1("mem_ren", c, mem_ren, in_busy && !m_we);
         chk1("mem_wen", c, mem_wen, in_busy && m_we);
         chk1("i_done", c, i_done, in_done && !m_owner);
         chk1("d_done", c, d_done, in_done && m_owner);
         chk1("i_err", c, i_err, in_done && !m_owner && cur_to);
         chk1("d_err", c, d_err, in_done && m_owner && cur_to);
         chk1("owner", c, owner, m_owner);
         chk32("rdata", c, rdata, m_rdata);
         chk32("mem_addr", c, mem_addr, m_addr);
         chk32("mem_wdata", c, mem_wdata, m_wdata);
         chk32("mem_be", c, 32'(mem_be), 32'(m_be));

         if (in_busy && (c >= g + 2) && rst_cnt < 4 && $urandom_range(0, 19) == 0) begin
            // abort mid-transaction: strobes and busy must fall without a clock edge
            reset = 1'b1;
            #1;
            chk1("rst_ren", c, mem_ren, 1'b0);
            chk1("rst_wen", c, mem_wen, 1'b0);
            chk1("rst_busy", c, busy, 1'b0);
            chk1("rst_done", c, i_done || d_done, 1'b0);
            rst_cnt++;
            active = 1'b0; m_last = 1'b1; m_owner = 1'b0;
            m_addr = '0; m_wdata = '0; m_be = '0; m_rdata = '0;
            i_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0;
            next_edge = c + 1;
            force_tie = 1'b1;
         end else begin
            if (in_done && !m_owner) i_req = 1'b0;
            else if (!i_req && (force_tie || $urandom_range(0, 3) == 0)) begin
               i_req = 1'b1; i_we = 1'($urandom_range(0, 1));
               i_addr = $urandom; i_wdata = $urandom; i_be = 4'($urandom);
            end
            if (in_done && m_owner) d_req = 1'b0;
            else if (!d_req && (force_tie || $urandom_range(0, 3) == 0)) begin
               d_req = 1'b1; d_we = 1'($urandom_range(0, 1));
               d_addr = $urandom; d_wdata = $urandom; d_be = 4'($urandom);
            end
            force_tie = 1'b0;
            if (active && c == ready_c) begin
               mem_ready = 1'b1; mem_rdata = cur_rdata;
            end else if (active && (c >= g + 1) && (c < done_c)) begin
               mem_ready = 1'b0; mem_rdata = $urandom;
            end else begin
               mem_ready = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
            end
         end

         @(posedge clk);
         if (!reset && c >= next_edge && (i_req || d_req)) begin
            win     = (i_req && d_req) ? !m_last : d_req;
            m_last  = win;
            m_owner = win;
            m_we    = win ? d_we : i_we;
            m_addr  = win ? d_addr : i_addr;
            m_wdata = win ? d_wdata : i_wdata;
            m_be    = win ? d_be : i_be;
            k       = $urandom_range(1, TO + 1);
            cur_to  = (k > TO);
            lat     = cur_to ? TO : k;
            g       = c;
            ready_c = cur_to ? -1 : g + k;
            done_c  = g + lat + 1;
            next_edge = done_c + 1;
            cur_rdata = $urandom;
            active  = 1'b1;
         end
         @(negedge clk);
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter sharing the single backing memory port between the instruction-side and data-side cache controllers of the RISC-V core. Each side issues one read or write transaction at a time. The arbiter picks a winner round-robin, latches its command, and holds the memory strobes until the memory signals ready. It then returns read data with a one-cycle done pulse, and aborts with an error if the memory does not respond within a bounded time.

## Interface
- TIMEOUT, 255: max BUSY cycles without mem_ready before abort; 1..255.
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high.
- i_req  in  1  instruction-side request, level.
- i_we  in  1  instruction-side write (1) / read (0).
- i_addr  in  32  instruction-side word address.
- i_wdata  in  32  instruction-side write data.
- i_be  in  4  instruction-side byte enables.
- i_done  out  1  one-cycle completion pulse to instruction side.
- i_err  out  1  valid with i_done; 1 = timed out.
- d_req, d_we, d_addr, d_wdata, d_be  in  1/1/32/32/4  data-side equivalents.
- d_done, d_err  out  1/1  data-side equivalents.
- rdata  out  32  read data; valid while i_done or d_done is high.
- mem_ren  out  1  memory read strobe.
- mem_wen  out  1  memory write strobe.
- mem_addr  out  32  latched address.
- mem_wdata  out  32  latched write data.
- mem_be  out  4  latched byte enables.
- mem_ready  in  1  memory completion, sampled only in BUSY.
- mem_rdata  in  32  memory read data, captured when mem_ready is high in BUSY.
- busy  out  1  state != IDLE.
- owner  out  1  0 = instruction side, 1 = data side; owner of the current or last transaction.

## Operation
- States: IDLE, BUSY, DONE. Encoding is free.
- **IDLE:** requests are sampled only here. If neither req is high, stay in IDLE. If one req is high, it wins. If both are high, the winner is !last, where last is the side most recently granted.
- **IDLE on grant:**
  - Latch the winner's we/addr/wdata/be into the mem_* registers.
  - Set owner = winner and last = winner.
  - Clear the timeout counter.
  - Go to BUSY.
- **BUSY:**
  - mem_ren = !we_latched and mem_wen = we_latched; both are registered and held for the whole of BUSY.
  - **mem_ready high:** capture mem_rdata into rdata (writes leave rdata unchanged), err = 0, go to DONE.
  - **mem_ready low:** increment the counter. When the counter equals TIMEOUT-1 on a low-ready edge, set err = 1 and go to DONE. In that case rdata is unchanged.
- **DONE:**
  - Assert owner's done (and err) for exactly one cycle; the other side's done stays 0.
  - Strobes are low.
  - Next state is always IDLE. Requests are ignored in DONE.
- Requester rule: keep req high until its done is seen, and drop it in the done cycle. If req is still high in IDLE, it is a new transaction.
- The mem_* address, data and byte-enable registers hold their last values outside BUSY. Only mem_ren and mem_wen are forced low outside BUSY.
- Reset values:
  - state = IDLE, last = 1 (instruction side wins the first tie), owner = 0.
  - All strobes, done and err = 0.
  - rdata, mem_addr, mem_wdata, mem_be = 0.
  - Counter = 0.
- Reset asserted mid-transaction aborts immediately. No done is produced for the aborted transaction, and strobes fall asynchronously.
- Counter is 8 bits. It never wraps, because exit occurs at TIMEOUT-1.

## Timing
- Edge numbering: edge n samples in IDLE, and the state is BUSY during cycle n+1.
- If mem_ready is high during cycle n+k, the state is DONE in cycle n+k+1 and IDLE in cycle n+k+2.
- Minimum occupancy is 3 cycles (ready on the first BUSY cycle). Maximum throughput is one transaction per 3 cycles.
- done pulses exactly 1 cycle after the mem_ready edge. rdata stays stable from that DONE cycle until the next capture.
- Timeout: done with err = 1 appears TIMEOUT+1 cycles after the grant edge.
- A req rising during BUSY or DONE waits. It is serviced at the first IDLE edge, where round-robin applies if both sides are pending.
- mem_ready high outside BUSY is ignored.

## Test plan
- **Single I read:** i_req, i_addr = 0x40; mem_ready at the 2nd BUSY cycle with mem_rdata = 0xDEADBEEF → mem_ren for 2 cycles, mem_addr = 0x40, i_done pulse with rdata = 0xDEADBEEF and i_err = 0; d_done stays 0.
- **Simultaneous requests after reset:** i_req and d_req both high → I is granted first (owner = 0). D follows at the next IDLE with owner = 1 and mem_wen for d_we = 1. A third tie is granted to I.
- **D write:** d_be = 4'b0011, d_wdata = 0x12345678 → mem_wen = 1, mem_ren = 0, mem_be = 0011; d_done asserted and rdata unchanged.
- **Timeout:** TIMEOUT = 4, mem_ready held low → d_done with d_err = 1 at 5 cycles after the grant edge; strobes low in DONE.
- **Reset in BUSY:** reset pulsed on the 2nd BUSY cycle → strobes drop immediately, no done pulses, busy = 0. Next request is arbitrated normally with the I-side tie priority.
- **Late request:** d_req rises during I's BUSY → it is not granted until IDLE, then completes with the correct owner; mem_ready pulses outside BUSY cause no done.
